leftshift_seq: RTL and testbench

//  Multi-cycle left shifter/rotator, the left-direction companion of the

---
 rtl/leftshift_seq_pkg.sv | 14 +
 rtl/leftshift_seq_leftshiftn.sv | 21 ++
 rtl/leftshift_seq.sv | 122 ++++++++++++
 tb/tb_leftshift_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/leftshift_seq_pkg.sv
// Shared definitions for the multi-cycle left shifter/rotator:
// FSM state encodings and default operand geometry.
package leftshift_seq_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/leftshift_seq_leftshiftn.sv
// Combinational left shift (zero fill) or left rotate by a fixed amount N;
// the left-direction mirror of rightshiftn.
module leftshiftn #(
    parameter int WIDTH = 32,
    parameter int N     = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic             rot,
    output logic [WIDTH-1:0] out
);

    // Rotate refills the low bits with the bits pushed off the top.
    always_comb begin
        if (rot) begin
            out = {a[WIDTH-1-N:0], a[WIDTH-1:WIDTH-N]};
        end else begin
            out = {a[WIDTH-1-N:0], {N{1'b0}}};
        end
    end

endmodule

// File: rtl/leftshift_seq.sv
// Multi-cycle left shifter/rotator: one power-of-two stage per clock,
// shamt consumed LSB first, fixed latency regardless of shift amount.
module leftshift_seq
    import leftshift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic             rot,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int            KW     = (SHW > 1) ? $clog2(SHW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SHW - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   sh;
    logic             r;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] stage_out [SHW];
    logic [WIDTH-1:0] stage_sel;

    for (genvar i = 0; i < SHW; i++) begin : g_stage
        leftshiftn #(.WIDTH(WIDTH), .N(1 << i)) u_stage (
            .a   (acc),
            .rot (r),
            .out (stage_out[i])
        );
    end

    // Pick the stage for the current step; a clear shamt bit passes acc through.
    always_comb begin
        if (sh[k]) begin
            stage_sel = stage_out[k];
        end else begin
            stage_sel = acc;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE accepts a new start without a bubble.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (k == K_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, per-step accumulation and final result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= {WIDTH{1'b0}};
            sh  <= {SHW{1'b0}};
            r   <= 1'b0;
            k   <= {KW{1'b0}};
            out <= {WIDTH{1'b0}};
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        acc <= a;
                        sh  <= shamt;
                        r   <= rot;
                        k   <= {KW{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    acc <= stage_sel;
                    k   <= k + KW'(1);
                    if (k == K_LAST) begin
                        out <= stage_sel;
                    end
                end
                default: begin
                    k <= {KW{1'b0}};
                end
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_leftshift_seq.sv
// Self-checking bench for leftshift_seq: directed scenarios plus randomized
// operations checked against an arithmetic shift/rotate reference.
module tb_leftshift_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        rot;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    leftshift_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .shamt (shamt),
        .rot   (rot),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [31:0] x, input int s, input logic rt);
        logic [63:0] dbl;
        logic [31:0] shl;
        dbl = {x, x} << s;
        shl = x << s;
        if (rt) return dbl[63:32];
        else    return shl;
    endfunction

    // Launch one operation (single-cycle start) and wait for done.
    // Returns cycles from start sampling to done and busy-cycle count.
    task automatic run_op(input logic [31:0] xa, input logic [4:0] xs, input logic xr,
                          output int lat, output int nbusy);
        @(negedge clk);
        a = xa; shamt = xs; rot = xr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 32'h0; shamt = 5'd0; rot = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({busy, done, out} !== {1'b0, 1'b0, 32'h0}) $display("FAIL reset: busy=%b done=%b out=%h want 0 0 0", busy, done, out);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'h0000_0001, 32'h8000_0001, 32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [4:0]  ts [6] = '{5'd31, 5'd1, 5'd1, 5'd16, 5'd0, 5'd8};
        logic        tr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] te [6] = '{32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h3456_7812};
        int lat, nb;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], ts[i], tr[i], lat, nb);
            chk_cnt++;
            if (lat !== 6) $display("FAIL dir%0d_latency: got %0d want 6", i, lat);
            else pass_cnt++;
            chk_cnt++;
            if (nb !== 5) $display("FAIL dir%0d_busy_cycles: got %0d want 5", i, nb);
            else pass_cnt++;
            chk_cnt++;
            if (out !== te[i] || busy !== 1'b0) $display("FAIL dir%0d_out: got %h busy=%b want %h busy=0", i, out, busy, te[i]);
            else pass_cnt++;
            @(negedge clk);
            chk_cnt++;
            if (done !== 1'b0 || out !== te[i]) $display("FAIL dir%0d_done_pulse: done=%b out=%h want 0 %h", i, done, out, te[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        int lat, nb;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 32; s++) begin
                run_op(32'hA5A5_A5A5, 5'(s), 1'(r), lat, nb);
                exp = ref_model(32'hA5A5_A5A5, s, 1'(r));
                chk_cnt++;
                if (out !== exp || lat !== 6) $display("FAIL sweep_r%0d_s%0d: out=%h lat=%0d want %h lat=6", r, s, out, lat, exp);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] xa, exp;
        logic [4:0]  xs;
        logic        xr;
        int lat, nb;
        for (int i = 0; i < 40; i++) begin
            xa = $urandom;
            xs = 5'($urandom_range(31, 0));
            xr = 1'($urandom_range(1, 0));
            run_op(xa, xs, xr, lat, nb);
            exp = ref_model(xa, int'(xs), xr);
            chk_cnt++;
            if (out !== exp || lat !== 6) $display("FAIL rand%0d a=%h s=%0d r=%b: out=%h lat=%0d want %h lat=6", i, xa, xs, xr, out, lat, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, cyc;
        @(negedge clk);
        a = 32'h0000_0001; shamt = 5'd31; rot = 1'b0; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
        chk_cnt++;
        if (lat !== 6 || out !== 32'h8000_0000) $display("FAIL b2b_first: lat=%0d out=%h want 6 80000000", lat, out);
        else pass_cnt++;
        a = 32'h0000_00F0; shamt = 5'd4; rot = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_no_bubble: busy=%b done=%b want 1 0", busy, done);
        else pass_cnt++;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk_cnt++;
        if (cyc !== 6 || out !== 32'h0000_0F00) $display("FAIL b2b_second: gap=%0d out=%h want 6 00000f00", cyc, out);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        logic [31:0] exp;
        int lat, extra;
        exp = ref_model(32'h0F0F_1234, 7, 1'b1);
        @(negedge clk);
        a = 32'h0F0F_1234; shamt = 5'd7; rot = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'hDEAD_BEEF; shamt = 5'd3; rot = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 32'h0; shamt = 5'd0;
        lat = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk_cnt++;
        if (lat !== 6 || out !== exp) $display("FAIL ignore_result: lat=%0d out=%h want 6 %h", lat, out, exp);
        else pass_cnt++;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk_cnt++;
        if (extra !== 0 || out !== exp) $display("FAIL ignore_no_extra: active_cycles=%0d out=%h want 0 %h", extra, out, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int act;
        @(negedge clk);
        a = 32'h1111_2222; shamt = 5'd9; rot = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b1 || out === 32'h0) $display("FAIL rstmid_pre: busy=%b out=%h want busy 1 and nonzero out", busy, out);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({busy, done, out} !== {1'b0, 1'b0, 32'h0}) $display("FAIL rstmid_async: busy=%b done=%b out=%h want 0 0 0", busy, done, out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) act++;
        end
        chk_cnt++;
        if (act !== 0 || out !== 32'h0) $display("FAIL rstmid_quiet: active_cycles=%0d out=%h want 0 0", act, out);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_sweep();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
